// File: rtl/pc_fetch_sequencer.sv
// PC register and IF-stage fetch sequencer.
// Handles fixed-priority redirects, stalls and a variable-latency imem handshake.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exception,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [1:0]  pend_prio_q, pend_prio_d;

  logic [1:0]  cur_prio;
  logic [31:0] cur_target;
  logic [31:0] win_target;
  logic        redirect;
  logic        cur_wins;

  // Priority code: 3 = exception, 2 = branch, 1 = jump, 0 = none
  always_comb begin
    cur_prio   = 2'd0;
    cur_target = 32'h0;
    if (exception) begin
      cur_prio   = 2'd3;
      cur_target = EXC_VECTOR;
    end else if (branch_taken) begin
      cur_prio   = 2'd2;
      cur_target = branch_target;
    end else if (jump) begin
      cur_prio   = 2'd1;
      cur_target = jump_target;
    end
    cur_target[1:0] = 2'b00;
  end

  assign redirect   = (cur_prio != 2'd0);
  assign cur_wins   = !pend_valid_q || (cur_prio >= pend_prio_q);
  assign win_target = cur_wins ? cur_target : pend_target_q;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign imem_req = (state_q != S_BOOT);

  assign fetch_valid = (state_q == S_FETCH || state_q == S_WAIT)
                     && imem_ready && !stall && !redirect
                     && !pend_valid_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    pend_prio_d   = pend_prio_q;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (redirect) begin
          pc_d = cur_target;
        end else if (!imem_ready) begin
          state_d = S_WAIT;
        end else if (!stall) begin
          pc_d = pc_plus4;
        end
      end
      S_WAIT: begin
        if (!imem_ready) begin
          if (redirect && cur_wins) begin
            pend_valid_d  = 1'b1;
            pend_target_d = cur_target;
            pend_prio_d   = cur_prio;
          end
        end else begin
          state_d = S_FETCH;
          if (redirect || pend_valid_q) begin
            pc_d         = win_target;
            pend_valid_d = 1'b0;
          end else if (!stall) begin
            pc_d = pc_plus4;
          end
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
      pend_prio_q   <= 2'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      pend_prio_q   <= pend_prio_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer.
// Per-cycle expectations and delivered-fetch addresses are queued then checked.
module tb_pc_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        exception;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;

  typedef struct packed {
    logic [31:0] pc;
    logic        req;
    logic        fv;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fetch_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .exception     (exception),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_ready    (imem_ready),
    .imem_req      (imem_req),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .fetch_valid   (fetch_valid)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Every delivered instruction must match the next queued fetch address
  always @(negedge clk) begin
    if (fetch_valid === 1'b1) begin
      if (fetch_q.size() == 0) begin
        chk("fetch_unexpected", pc, 32'hxxxx_xxxx);
      end else begin
        chk("fetch_addr", pc, fetch_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic        rst,
                     input logic        stl,
                     input logic        exc,
                     input logic        br,
                     input logic [31:0] bt,
                     input logic        jp,
                     input logic [31:0] jt,
                     input logic        rdy,
                     input logic [31:0] epc,
                     input logic        ereq,
                     input logic        efv);
    exp_t e;
    reset         = rst;
    stall         = stl;
    exception     = exc;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    imem_ready    = rdy;
    exp_q.push_back('{pc: epc, req: ereq, fv: efv});
    if (efv) fetch_q.push_back(epc);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("pc", pc, e.pc);
    chk("pc_plus4", pc_plus4, e.pc + 32'd4);
    chk("imem_req", {31'h0, imem_req}, {31'h0, e.req});
    chk("fetch_valid", {31'h0, fetch_valid}, {31'h0, e.fv});
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    stall         = 1'b0;
    exception     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump          = 1'b0;
    jump_target   = 32'h0;
    imem_ready    = 1'b0;
    @(posedge clk);
    #1;
    // reset state and boot cycle
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 32'h00, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h00, 0, 0);
    // free run
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h00, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h04, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h08, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h0C, 1, 1);
    // stall at 0x10
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 0, 0, 0, 0, 0, 1, 32'h10, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h14, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h18, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h1C, 1, 1);
    // memory wait at 0x20
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h20, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h20, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h20, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h24, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h28, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h2C, 1, 1);
    // redirects while waiting at 0x30: branch beats jump
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h30, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h100, 0, 32'h30, 1, 0);
    cyc(0, 0, 0, 1, 32'h203, 0, 0, 0, 32'h30, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h30, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 1, 1);
    // jump in FETCH, then all three redirects at once
    cyc(0, 0, 0, 0, 0, 1, 32'h40, 1, 32'h204, 1, 0);
    cyc(0, 0, 1, 1, 32'h300, 1, 32'h400, 1, 32'h40, 1, 0);
    // redirect wins over stall, then wrap
    cyc(0, 1, 0, 1, 32'hFFFF_FFFE, 0, 0, 1, 32'h80, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h00, 1, 1);
    // pending exception not displaced by branch or current jump
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h04, 1, 0);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 32'h04, 1, 0);
    cyc(0, 0, 0, 1, 32'h500, 0, 0, 0, 32'h04, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h600, 1, 32'h04, 1, 0);
    // equal priority replaces pending
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h80, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h700, 0, 32'h80, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h710, 0, 32'h80, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h80, 1, 0);
    // current branch beats pending jump on consumption
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h710, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h800, 0, 32'h710, 1, 0);
    cyc(0, 0, 0, 1, 32'h900, 0, 0, 1, 32'h710, 1, 0);
    // reset in WAIT with a pending redirect
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h900, 1, 0);
    cyc(0, 0, 0, 1, 32'hA00, 0, 0, 0, 32'h900, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h900, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h00, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h00, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h04, 1, 1);
    // stall with ready in WAIT refetches same pc
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'h08, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 1, 32'h08, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h08, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h0C, 1, 1);
    chk("fetch_q_drained", fetch_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Owns the architectural PC register and sequences instruction fetch for the IF stage of the 5-stage pipeline.
- Selects next PC from sequential (PC+4), branch, jump or exception vector, with fixed priority.
- Handles hazard-unit stalls and a variable-latency instruction memory via a req/ready handshake.
- Redirects arriving while a fetch is outstanding are held in a pending register; the in-flight instruction is squashed.

Parameters:
RESET_VECTOR  32'h0000_0000  PC value loaded on reset
EXC_VECTOR    32'h0000_0080  PC value loaded on exception

Ports:
clk            input   1   system clock, rising edge
reset          input   1   synchronous, active-high reset
stall          input   1   hazard unit: hold IF, do not advance PC
exception      input   1   redirect to EXC_VECTOR (highest priority)
branch_taken   input   1   redirect to branch_target
branch_target  input   32  branch destination
jump           input   1   redirect to jump_target
jump_target    input   32  jump destination
imem_ready     input   1   instruction memory: access at pc completes this cycle
imem_req       output  1   fetch request; address is pc
pc             output  32  current fetch address (registered)
pc_plus4       output  32  pc + 4, for link / IF-ID latch
fetch_valid    output  1   instruction returned this cycle is to be latched into IF/ID

Behaviour:
- One clock domain; all state updates on rising clk. Reset is synchronous, active-high, and overrides every other input. It may be asserted in any state, including mid-fetch.
- Reset values: pc=RESET_VECTOR, state=BOOT, pend_valid=0, pend_target=0, imem_req=0, fetch_valid=0.
- Redirect target: exception ? EXC_VECTOR : branch_taken ? branch_target : jump ? jump_target.
  - Targets have bits [1:0] forced to 2'b00.
  - "redirect" means any of exception, branch_taken or jump is high.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- fetch_valid is combinational and high only when all of the following hold:
  - state is FETCH or WAIT;
  - imem_ready=1;
  - stall=0;
  - no redirect this cycle;
  - pend_valid=0.
- imem_req = (state != BOOT).
- States:
  - BOOT: imem_req=0. Lasts exactly one cycle after reset release, then goes to FETCH. Redirect inputs are ignored.
  - FETCH (request issued, pc stable):
    - Redirect this cycle: pc <= target, stay FETCH. The current access is abandoned and imem_ready is ignored.
    - Else imem_ready=0: go to WAIT, pc held.
    - Else stall=1: pc held, stay FETCH. The same address is refetched next cycle.
    - Else: pc <= pc+4, stay FETCH. Back-to-back 1-cycle fetches give one instruction per cycle.
  - WAIT (access outstanding, pc and imem_req held stable):
    - imem_ready=0 and redirect this cycle: capture into pend_target and set pend_valid.
      - A new redirect replaces a pending one only if its priority is >= the pending one (exception > branch > jump). Priority of the pending entry is tracked with a 2-bit code.
    - imem_ready=1, with pend_valid or a redirect this cycle: pc <= higher-priority of (current redirect, pending). Clear pend_valid, fetch_valid=0, go to FETCH.
    - imem_ready=1, stall=1: pc held, go to FETCH (refetch).
    - imem_ready=1 otherwise: pc <= pc+4, go to FETCH.
- stall has no effect on redirect handling: a redirect always wins over stall.
- pc never changes while in WAIT.
- pend_valid is cleared only on consumption or reset.

Test Plan:
- Reset then free-run, imem_ready=1: cycle after reset pc=0, imem_req=0; then pc=0,4,8,12 on consecutive cycles, fetch_valid=1 each FETCH cycle.
- stall=1 for 3 cycles at pc=0x10 with imem_ready=1: pc stays 0x10, fetch_valid=0; after release next pc=0x14.
- Memory wait: imem_ready=0 for 2 cycles at pc=0x20, then 1: state FETCH->WAIT->WAIT->FETCH, pc=0x20 throughout, then 0x24; fetch_valid=1 only on the ready cycle.
- Redirect during wait: at pc=0x30 in WAIT, jump to 0x100, next cycle branch_taken to 0x203, then imem_ready=1: fetch_valid=0 on ready cycle, pc becomes 0x200 (branch beats jump, low bits cleared).
- Simultaneous redirects in FETCH: exception, branch_taken and jump all high at pc=0x40: pc=EXC_VECTOR (0x80) next cycle.
- Wrap and reset mid-operation: pc=32'hFFFF_FFFC, ready=1 gives pc=0. Assert reset while in WAIT with pend_valid=1: next cycle pc=RESET_VECTOR, state=BOOT, pend_valid=0, imem_req=0.
